pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage ARM core.
- Merges the hazard unit's freeze with EXE-stage branch redirects and multi-cycle MEM-stage memory accesses.
- Outputs per-stage hold/flush controls, a memory start handshake, a sticky timeout error and a saturating stall counter.
- Sits between the hazard detector, the EXE branch logic, the MEM stage and the SRAM controller.

Parameters:
- TIMEOUT, 64, max MEM_BUSY cycles waiting for sram_ready before abort (>=2).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard  in  1  freeze request from the hazard detector.
- branch_taken  in  1  EXE-stage branch/B-type taken.
- mem_r_en  in  1  MEM-stage load valid.
- mem_w_en  in  1  MEM-stage store valid.
- sram_ready  in  1  memory controller completion; one-cycle pulse.
- freeze_all  out  1  hold every pipeline register and the PC.
- if_freeze  out  1  hold PC and IF/ID register.
- if_id_flush  out  1  clear IF/ID register.
- id_exe_flush  out  1  load bubble into ID/EXE register.
- mem_start  out  1  one-cycle start pulse to the memory controller.
- mem_start_wr  out  1  access type qualifier with mem_start: 1 = store.
- mem_busy  out  1  state == MEM_BUSY.
- mem_timeout  out  1  sticky; set on timeout abort.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - All combinational outputs are 0 while rst=1, regardless of inputs.
- States: RUN, MEM_BUSY.
- mem_req = mem_r_en | mem_w_en.
- RUN with mem_req=1:
  - Same cycle: mem_start=1, mem_start_wr=mem_w_en, freeze_all=1.
  - Next state MEM_BUSY; wait_cnt=0.
- RUN with mem_req=0: freeze_all=0. sram_ready is ignored in RUN.
- MEM_BUSY:
  - freeze_all = ~sram_ready. The ready cycle releases the pipeline so MEM/WB captures read data.
  - sram_ready=1 -> next state RUN. If the newly advanced MEM instruction also accesses memory, a new mem_start is issued in the following RUN cycle.
  - sram_ready=0 -> wait_cnt+1.
  - wait_cnt==TIMEOUT-1 and sram_ready=0 -> freeze_all=0 that cycle, mem_timeout<=1, next state RUN.
  - mem_start is never asserted in MEM_BUSY.
- Minimum memory stall: 1 cycle (start cycle), with ready in the first MEM_BUSY cycle.
- Priority: freeze_all > branch_taken > hazard. When freeze_all=1: if_freeze, if_id_flush and id_exe_flush are all 0.
- Outputs with freeze_all=0:
  - if_id_flush = branch_taken.
  - id_exe_flush = branch_taken | hazard.
  - if_freeze = hazard & ~branch_taken. A branch redirect must load the PC; the stalled instruction in ID is squashed anyway.
- Branch during a memory stall: EXE is held, so branch_taken stays high and is acted on in the release cycle.
- stall_cycles: +1 on any cycle with freeze_all | if_freeze. Holds at 2^CNT_W-1, no wrap.
- mem_timeout: cleared only by rst.
- Reset mid-MEM_BUSY: the access is abandoned, next state RUN, no mem_start during the reset cycle.
- No combinational path from any output back to an input. mem_start depends only on state and mem_req.

Test Plan:
- Reset, then idle 5 cycles with all inputs 0 -> all outputs 0, stall_cycles=0.
- Load (mem_r_en=1) at T0, sram_ready pulse at T3:
  - mem_start=1 at T0 only; mem_start_wr=0.
  - freeze_all=1 at T0-T2, 0 at T3; mem_busy=1 at T1-T3.
  - stall_cycles=3.
- Store, then hazard=1 for 2 cycles after release -> mem_start_wr=1; if_freeze=1 and id_exe_flush=1 for 2 cycles; stall_cycles increments by 2.
- hazard=1 and branch_taken=1 together -> if_freeze=0, if_id_flush=1, id_exe_flush=1; PC must advance.
- Branch held during a 4-cycle memory stall -> no flush during the freeze; if_id_flush=id_exe_flush=1 in the release cycle.
- TIMEOUT=4, sram_ready never asserted:
  - freeze_all drops in the 4th MEM_BUSY cycle; mem_timeout=1 the next cycle and stays set.
  - Assert rst mid-stall -> state RUN and all outputs 0.
  - Drive stall_cycles to saturation with CNT_W=4 -> holds at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges hazard freeze, branch redirects and multi-cycle memory stalls into pipeline controls
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             freeze_all,
  output logic             if_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_start,
  output logic             mem_start_wr,
  output logic             mem_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic {RUN, MEM_BUSY} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic mem_req, busy, expire;
  always_comb begin
    mem_req = mem_r_en | mem_w_en;
    busy = state_q == MEM_BUSY;
    expire = busy & ~sram_ready & (wait_cnt_q == WW'(TIMEOUT - 1));
    freeze_all = ~rst & (busy ? ~sram_ready & ~expire : mem_req);
    mem_start = ~rst & ~busy & mem_req;
    mem_start_wr = mem_start & mem_w_en;
    mem_busy = ~rst & busy;
    if_id_flush = ~rst & ~freeze_all & branch_taken;
    id_exe_flush = ~rst & ~freeze_all & (branch_taken | hazard);
    if_freeze = ~rst & ~freeze_all & hazard & ~branch_taken;
    state_d = busy ? ((sram_ready | expire) ? RUN : MEM_BUSY) : (mem_req ? MEM_BUSY : RUN);
    wait_cnt_d = busy ? wait_cnt_q + 1'b1 : '0;
    mem_timeout_d = mem_timeout_q | expire;
    stall_cycles_d = ((freeze_all | if_freeze) & ~&stall_cycles_q) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    mem_timeout = mem_timeout_q;
    stall_cycles = stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_cnt_q <= '0;
      mem_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule
